// File: rtl/pole_cancel_fir.sv
// All-zero prediction-error filter e[n] = x[n] + A1*x[n-1] + A2*x[n-2] in Q14,
// sharing one multiplier over three MAC cycles per sample with valid/ready on both sides.
module pole_cancel_fir #(
    parameter int A1     = -30885,
    parameter int A2     = 16242,
    parameter int COEF_W = 16,
    parameter int DIN_W  = 12,
    parameter int DOUT_W = 12,
    parameter int SHIFT  = 14
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     clear_hist,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DIN_W-1:0]  in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DOUT_W-1:0] out_data,
    output logic                     out_sat
);

    localparam int PROD_W = DIN_W + COEF_W;
    localparam int ACC_W  = PROD_W + 2;

    localparam logic signed [COEF_W-1:0] C0      = COEF_W'(2 ** SHIFT);
    localparam logic signed [COEF_W-1:0] C1      = COEF_W'(A1);
    localparam logic signed [COEF_W-1:0] C2      = COEF_W'(A2);
    localparam logic signed [ACC_W-1:0]  RND     = ACC_W'(2 ** (SHIFT - 1));
    localparam logic signed [ACC_W-1:0]  OUT_MAX = ACC_W'(2 ** (DOUT_W - 1) - 1);
    localparam logic signed [ACC_W-1:0]  OUT_MIN = ACC_W'(-(2 ** (DOUT_W - 1)));

    typedef enum logic [4:0] {
        IDLE = 5'b00001,
        MAC0 = 5'b00010,
        MAC1 = 5'b00100,
        MAC2 = 5'b01000,
        OUT  = 5'b10000
    } state_e;

    state_e                     state_q, state_d;
    logic signed [DIN_W-1:0]    x0_q, x1_q, x2_q;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [DOUT_W-1:0]   out_data_q, out_data_d;
    logic                       out_sat_q, out_sat_d;

    logic signed [DIN_W-1:0]    mul_a;
    logic signed [COEF_W-1:0]   mul_b;
    logic signed [PROD_W-1:0]   prod;
    logic signed [ACC_W-1:0]    sum;
    logic signed [ACC_W-1:0]    res;

    // Single multiplier: the tap is selected by which MAC state is active.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        mul_a = x0_q;
        mul_b = C0;
        case (state_q)
            MAC1: begin mul_a = x1_q; mul_b = C1; end
            MAC2: begin mul_a = x2_q; mul_b = C2; end
            default: ;
        endcase
    end

    assign prod = PROD_W'(mul_a) * PROD_W'(mul_b);
    assign sum  = acc_q + ACC_W'(prod);
    assign res  = (sum + RND) >>> SHIFT;

    always_comb begin
        out_data_d = DOUT_W'(res);
        out_sat_d  = 1'b0;
        if (res > OUT_MAX) begin
            out_data_d = DOUT_W'(OUT_MAX);
            out_sat_d  = 1'b1;
        end else if (res < OUT_MIN) begin
            out_data_d = DOUT_W'(OUT_MIN);
            out_sat_d  = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = MAC0;
            MAC0:    state_d = MAC1;
            MAC1:    state_d = MAC2;
            MAC2:    state_d = OUT;
            OUT:     if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            x0_q       <= '0;
            x1_q       <= '0;
            x2_q       <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    // Clearing alongside a handshake means the new sample sees zero history.
                    if (clear_hist) begin
                        x1_q <= '0;
                        x2_q <= '0;
                    end
                    if (in_valid) begin
                        x0_q  <= in_data;
                        acc_q <= '0;
                    end
                end
                MAC0, MAC1: acc_q <= sum;
                MAC2: begin
                    out_data_q <= out_data_d;
                    out_sat_q  <= out_sat_d;
                    x2_q       <= x1_q;
                    x1_q       <= x0_q;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == OUT);
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_pole_cancel_fir.sv
// Bench for pole_cancel_fir: directed table from known results, hand-written
// reset/backpressure sequences, and random samples against an arithmetic model.
module tb_pole_cancel_fir;

    localparam int A1 = -30885;
    localparam int A2 = 16242;

    logic              clk = 1'b0;
    logic              nrst = 1'b0;
    logic              clear_hist = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic signed [11:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic signed [11:0] out_data;
    logic              out_sat;

    int checks = 0;
    int errors = 0;

    longint h1 = 0;
    longint h2 = 0;

    typedef struct {
        int din;
        bit clr;
        bit pre_clr;
        int stall;
        int exp_d;
        bit exp_s;
    } vec_t;

    vec_t tbl[$];

    pole_cancel_fir dut (
        .clk       (clk),
        .nrst      (nrst),
        .clear_hist(clear_hist),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference: direct evaluation of the difference equation, floor-rounded with +0.5 LSB.
    function automatic void model(input int d, input bit clr, output int ed, output bit es);
        longint s;
        if (clr) begin
            h1 = 0;
            h2 = 0;
        end
        s = (longint'(d) * 16384 + longint'(A1) * h1 + longint'(A2) * h2 + 8192) >>> 14;
        es = 1'b0;
        ed = int'(s);
        if (s > 2047) begin
            ed = 2047;
            es = 1'b1;
        end else if (s < -2048) begin
            ed = -2048;
            es = 1'b1;
        end
        h2 = h1;
        h1 = d;
    endfunction

    task automatic pulse_clear();
        clear_hist = 1'b1;
        in_valid   = 1'b0;
        @(posedge clk); #1;
        clear_hist = 1'b0;
    endtask

    // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 with the DUT back in IDLE.
    task automatic run_sample(input int d, input bit clr, input int stall,
                              input int exp_d, input bit exp_s, input string tag);
        int n;
        in_data    = 12'(d);
        in_valid   = 1'b1;
        clear_hist = clr;
        out_ready  = (stall == 0);
        check({tag, " in_ready_idle"}, longint'(in_ready), 1);
        @(posedge clk); #1;
        in_valid   = 1'b0;
        clear_hist = 1'b0;
        in_data    = 12'($urandom);
        check({tag, " in_ready_busy"}, longint'(in_ready), 0);
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " latency"}, n, 4);
        check({tag, " data"}, longint'(out_data), exp_d);
        check({tag, " sat"}, longint'(out_sat), exp_s);
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'($urandom);
            in_data  = 12'($urandom);
            @(posedge clk); #1;
            check({tag, " stall_valid"}, longint'(out_valid), 1);
            check({tag, " stall_data"}, longint'(out_data), exp_d);
            check({tag, " stall_sat"}, longint'(out_sat), exp_s);
            check({tag, " stall_in_ready"}, longint'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, " valid_drop"}, longint'(out_valid), 0);
    endtask

    initial begin
        int ed;
        bit es;
        int d;
        bit clr;
        bit pclr;
        int stall;

        // Impulse
        tbl.push_back('{1000, 1'b1, 1'b0, 0, 1000, 1'b0});
        tbl.push_back('{0,    1'b0, 1'b0, 0, -1885, 1'b0});
        tbl.push_back('{0,    1'b0, 1'b0, 0, 991,  1'b0});
        tbl.push_back('{0,    1'b0, 1'b0, 0, 0,    1'b0});
        // Step
        tbl.push_back('{2047, 1'b1, 1'b0, 0, 2047, 1'b0});
        tbl.push_back('{2047, 1'b0, 1'b0, 0, -1812, 1'b0});
        tbl.push_back('{2047, 1'b0, 1'b0, 0, 218,  1'b0});
        // Saturation
        tbl.push_back('{2047,  1'b1, 1'b0, 0, 2047,  1'b0});
        tbl.push_back('{-2048, 1'b0, 1'b0, 0, -2048, 1'b1});
        tbl.push_back('{2047,  1'b0, 1'b0, 0, 2047,  1'b1});
        // Backpressure: stall pulses on in_valid must not disturb the history
        tbl.push_back('{1000, 1'b1, 1'b0, 10, 1000, 1'b0});
        tbl.push_back('{0,    1'b0, 1'b0, 0, -1885, 1'b0});
        // Standalone clear_hist in IDLE
        tbl.push_back('{1000, 1'b1, 1'b0, 0, 1000, 1'b0});
        tbl.push_back('{0,    1'b0, 1'b1, 0, 0,    1'b0});

        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", longint'(in_ready), 1);
        check("reset out_valid", longint'(out_valid), 0);
        check("reset out_data", longint'(out_data), 0);
        check("reset out_sat", longint'(out_sat), 0);
        nrst = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            if (tbl[i].pre_clr) pulse_clear();
            run_sample(tbl[i].din, tbl[i].clr, tbl[i].stall, tbl[i].exp_d, tbl[i].exp_s,
                       $sformatf("vec%0d", i));
        end

        // Reset during MAC1 of a 1000 sample: discarded, history cleared
        in_data    = 12'(1000);
        in_valid   = 1'b1;
        clear_hist = 1'b1;
        @(posedge clk); #1;
        in_valid   = 1'b0;
        clear_hist = 1'b0;
        @(posedge clk); #1;
        nrst = 1'b0;
        #1;
        check("midrst out_valid", longint'(out_valid), 0);
        check("midrst in_ready", longint'(in_ready), 1);
        check("midrst out_data", longint'(out_data), 0);
        repeat (2) @(posedge clk);
        #1;
        check("midrst held out_valid", longint'(out_valid), 0);
        nrst = 1'b1;
        @(posedge clk); #1;
        check("midrst after out_valid", longint'(out_valid), 0);
        run_sample(0, 1'b0, 0, 0, 1'b0, "midrst_next");

        // Random samples against the model
        h1 = 0;
        h2 = 0;
        for (int k = 0; k < 150; k++) begin
            case ($urandom_range(0, 3))
                0:       d = ($urandom_range(0, 1) != 0) ? 2047 : -2048;
                default: d = int'($urandom_range(0, 4095)) - 2048;
            endcase
            clr   = (k == 0) || ($urandom_range(0, 7) == 0);
            pclr  = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            if (pclr) begin
                pulse_clear();
                h1 = 0;
                h2 = 0;
            end
            model(d, clr, ed, es);
            run_sample(d, clr, stall, ed, es, $sformatf("rnd%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pole_cancel_fir.md
Name: pole_cancel_fir

Overview:
- Inverse (analysis) counterpart to the team's Q14 second-order-section IIR filter.
- Computes the all-zero prediction-error output e[n] = x[n] + a1*x[n-1] + a2*x[n-2]. This cancels the pole pair a1/a2 that the IIR section synthesises.
- Placed in the bench/measurement path to whiten or undo a biquad's recursive part.
- Uses one shared multiplier sequenced over 3 cycles per sample, with valid/ready handshakes on both sides.

Parameters:
- A1, -30885, Q14 coefficient for x[n-1] (signed, COEF_W bits).
- A2, 16242, Q14 coefficient for x[n-2].
- COEF_W, 16, coefficient width, signed.
- DIN_W, 12, input sample width, signed two's complement.
- DOUT_W, 12, output sample width, signed.
- SHIFT, 14, fractional bits of the coefficients; the unity tap equals 2**SHIFT.

Ports:
- clk  in  1  clock.
- nrst  in  1  asynchronous, active-low reset.
- clear_hist  in  1  synchronous; zeroes x1/x2 history; honoured only in IDLE.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample; equals (state==IDLE).
- in_data  in  DIN_W  input sample x[n].
- out_valid  out  1  out_data/out_sat valid.
- out_ready  in  1  downstream accepts output.
- out_data  out  DOUT_W  rounded, saturated e[n].
- out_sat  out  1  set when out_data was clipped; qualified by out_valid.

Behaviour:
- Reset (nrst=0, asynchronous): state=IDLE; x0, x1, x2, acc, out_data, out_sat, out_valid all 0; in_ready=1.
- State IDLE:
  - in_ready=1.
  - in_valid&in_ready: x0<=in_data, acc<=0, go to MAC0.
  - clear_hist with no handshake: x1, x2<=0.
  - clear_hist together with a handshake: history cleared first, then the sample is processed with zero history.
- State MAC0: acc<=acc + (2**SHIFT)*x0, go to MAC1.
- State MAC1: acc<=acc + A1*x1, go to MAC2.
- State MAC2:
  - Compute r = (acc + A2*x2 + 2**(SHIFT-1)) >>> SHIFT. This is round-half-up with an arithmetic shift.
  - Saturate r to [-2**(DOUT_W-1), 2**(DOUT_W-1)-1]; out_sat=1 iff clipped.
  - Register out_data and out_sat.
  - Shift history: x2<=x1, x1<=x0.
  - Go to OUT.
- State OUT:
  - out_valid=1; out_data and out_sat held stable.
  - out_ready=1: out_valid<=0, go to IDLE.
  - Otherwise stay in OUT indefinitely with no data change.
- Timing: handshake in cycle T; MAC0/MAC1/MAC2 occupy T+1..T+3; out_valid rises at T+4.
- Throughput: minimum 5 cycles per sample when out_ready is held high. in_ready=0 from T+1 until the state returns to IDLE.
- Widths:
  - Products are full precision, DIN_W+COEF_W bits.
  - acc is ACC_W = DIN_W+COEF_W+2 bits signed, so no internal overflow for any input/coefficient.
  - Only the final result is saturated.
- One multiplier instance, operands muxed by state; no combinational path from in_data to out_data.
- Reset mid-operation (any state): immediate return to the reset values.
  - The in-flight sample is discarded and history is cleared.
  - The next accepted sample is treated as x[0] with zero history.
- in_valid while in_ready=0 is ignored. The source must hold in_valid/in_data until it sees in_ready=1.
- Encoding: one-hot, 5 states; an illegal state recovers to IDLE on the next clock.

Test Plan:
- Impulse: samples 1000, 0, 0, 0 with out_ready=1 -> out_data 1000, -1885, 991, 0; out_sat=0; each out_valid 4 cycles after its handshake.
- Step: 2047 held for three samples -> 2047, -1812, 218; out_sat=0 throughout.
- Saturation: 2047, -2048, 2047 -> 2047 (out_sat=0), -2048 (out_sat=1), 2047 (out_sat=1).
- Backpressure:
  - Stimulus: impulse 1000, then out_ready=0 for 10 cycles once out_valid rises.
  - Required: out_valid and out_data=1000 stay stable throughout; in_ready=0; in_valid pulses during the stall are not accepted.
  - After out_ready=1, the next sample is accepted one cycle later.
- clear_hist: feed 1000, then assert clear_hist in IDLE, then feed 0 -> second output 0, not -1885.
- Mid-operation reset: assert nrst=0 during MAC1 of sample 1000, release, then feed 0 -> out_data 0; no stale output; out_valid=0 during reset.
